// File: rtl/fp_mul_round.sv
// Post-multiply stage of the binary32 multiplier: normalize, round-to-nearest-even, pack.
// States: IDLE wait for product | NORM pick guard/sticky | ROUND rne increment | PACK saturate/flush/pack
module fp_mul_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [47:0] p,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_PACK} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [47:0]        r_p;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [22:0]        r_mant;
  logic               r_guard;
  logic               r_sticky;
  logic               r_zero;
  logic [31:0]        r_result;
  logic               r_done;
  logic               r_ovf;
  logic               r_unf;
  logic [23:0]        w_mant_inc;
  logic               w_round_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_en) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_PACK;
      S_PACK:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Carry out of bit 23 leaves the low 23 bits at zero, which is the wrapped mantissa.
  assign w_mant_inc = {1'b0, r_mant} + 24'd1;
  assign w_round_up = r_guard & (r_sticky | r_mant[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p      <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_en) begin
            r_p    <= p;
            r_sign <= sign_in;
            r_exp  <= exp_in;
          end
        end
        S_NORM: begin
          r_zero <= (r_p[47:46] == 2'b00);
          if (r_p[47]) begin
            r_mant   <= r_p[46:24];
            r_guard  <= r_p[23];
            r_sticky <= |r_p[22:0];
            r_exp    <= r_exp + 10'sd1;
          end else begin
            r_mant   <= r_p[45:23];
            r_guard  <= r_p[22];
            r_sticky <= |r_p[21:0];
          end
        end
        S_ROUND: begin
          if (w_round_up) begin
            r_mant <= w_mant_inc[22:0];
            if (w_mant_inc[23]) r_exp <= r_exp + 10'sd1;
          end
        end
        S_PACK: begin
          r_done <= 1'b1;
          if (r_zero) begin
            r_result <= {r_sign, 31'b0};
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end else if (r_exp >= 10'sd255) begin
            r_result <= {r_sign, 8'hFF, 23'b0};
            r_ovf    <= 1'b1;
            r_unf    <= 1'b0;
          end else if (r_exp <= 10'sd0) begin
            r_result <= {r_sign, 31'b0};
            r_ovf    <= 1'b0;
            r_unf    <= 1'b1;
          end else begin
            r_result <= {r_sign, r_exp[7:0], r_mant};
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fp_mul_round.sv
// Bench for fp_mul_round: arithmetic reference model plus directed vectors with literal results.
module tb_fp_mul_round;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [47:0] p = '0;
  logic        sign_in = 1'b0;
  logic [9:0]  exp_in = '0;
  logic [31:0] result;
  logic        done, busy, overflow, underflow;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  fp_mul_round dut (
    .clk(clk), .reset(reset), .in_en(in_en), .p(p), .sign_in(sign_in), .exp_in(exp_in),
    .result(result), .done(done), .busy(busy), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Reference: value-level normalize and round-half-even on the integer product.
  function automatic logic [33:0] model(input logic [47:0] pp, input logic s, input logic [9:0] e);
    longint sig, rem, half;
    int ex;
    logic [7:0] eb;
    logic [22:0] fr;
    ex = int'($signed(e));
    if (pp < 48'h400000000000) return {2'b00, s, 31'b0};
    if (pp >= 48'h800000000000) begin
      sig = longint'(pp) / 64'd16777216;
      rem = longint'(pp) % 64'd16777216;
      half = 64'd8388608;
      ex = ex + 1;
    end else begin
      sig = longint'(pp) / 64'd8388608;
      rem = longint'(pp) % 64'd8388608;
      half = 64'd4194304;
    end
    if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
    if (sig == 64'd16777216) begin
      sig = 64'd8388608;
      ex = ex + 1;
    end
    if (ex >= 255) return {2'b10, s, 8'hFF, 23'b0};
    if (ex <= 0)   return {2'b01, s, 31'b0};
    eb = ex[7:0];
    fr = sig[22:0];
    return {2'b00, s, eb, fr};
  endfunction

  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [33:0] m_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_done = 1'b0; m_res = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (in_en) begin
          m_pend = model(p, sign_in, exp_in);
          m_cnt = 3;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          {m_ovf, m_unf, m_res} = m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_busy", 32'(busy), 32'(m_cnt != 0));
      chk("cyc_result", result, m_res);
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [47:0] pp, input logic [9:0] e, input logic s,
                        input logic [31:0] req, input logic ro, input logic ru);
    int n;
    @(negedge clk);
    p = pp; exp_in = e; sign_in = s; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'd3);
    chk({nm, "_result"}, result, req);
    chk({nm, "_ovf"}, 32'(overflow), 32'(ro));
    chk({nm, "_unf"}, 32'(underflow), 32'(ru));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nd;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op("m15x15",  48'h900000000000, 10'd127, 1'b0, 32'h40100000, 1'b0, 1'b0);
    run_op("one",     48'h400000000000, 10'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_op("tie_even",48'h400000400000, 10'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_op("tie_odd", 48'h400000C00000, 10'd127, 1'b0, 32'h3F800002, 1'b0, 1'b0);
    run_op("sticky",  48'h400000400001, 10'd127, 1'b0, 32'h3F800001, 1'b0, 1'b0);
    run_op("carry",   48'h7FFFFFC00000, 10'd127, 1'b0, 32'h40000000, 1'b0, 1'b0);
    run_op("neg3",    48'hC00000000000, 10'd127, 1'b1, 32'hC0400000, 1'b0, 1'b0);
    run_op("ovf",     48'h900000000000, 10'd254, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    run_op("ovf_max", 48'h400000000000, 10'd381, 1'b1, 32'hFF800000, 1'b1, 1'b0);
    run_op("unf",     48'h400000000000, 10'd0,   1'b1, 32'h80000000, 1'b0, 1'b1);
    run_op("unf_neg", 48'h900000000000, 10'h382, 1'b0, 32'h00000000, 1'b0, 1'b1);
    run_op("clear",   48'h400000000000, 10'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    run_op("zero",    48'h000000000000, 10'd127, 1'b1, 32'h80000000, 1'b0, 1'b0);

    // Strobe held through NORM/ROUND/PACK with changing data: one done, first operand wins.
    @(negedge clk);
    p = 48'h900000000000; exp_in = 10'd127; sign_in = 1'b0; in_en = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) p = 48'h400000000000;
      if (i == 3) in_en = 1'b0;
      if (done) begin
        nd++;
        chk("ign_result", result, 32'h40100000);
      end
    end
    chk("ign_done_count", 32'(nd), 32'd1);

    // Back-to-back: new strobe in the done cycle.
    @(negedge clk);
    p = 48'h400000000000; exp_in = 10'd127; sign_in = 1'b0; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    wait_done(n);
    chk("b2b_a_result", result, 32'h3F800000);
    p = 48'hC00000000000; exp_in = 10'd127; sign_in = 1'b1; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    wait_done(n);
    chk("b2b_b_latency", 32'(n), 32'd3);
    chk("b2b_b_result", result, 32'hC0400000);

    // Reset while in ROUND.
    @(negedge clk);
    p = 48'h900000000000; exp_in = 10'd127; sign_in = 1'b0; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    run_op("after_rst", 48'h900000000000, 10'd127, 1'b0, 32'h40100000, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
